grid_bfs_path_engine: RTL and testbench

//  Clocked, parametrised shortest-path engine for a ROWS x COLS 4-connected grid.

---
 rtl/grid_pkg.sv | 54 +++++
 rtl/grid_bfs_fifo.sv | 63 ++++++
 rtl/grid_bfs_path_engine.sv | 217 +++++++++++++++++++++
 tb/tb_grid_bfs_path_engine.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared types and neighbour arithmetic for the grid BFS engine.
package grid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StPop,
    StExpand,
    StTrace,
    StFinish
  } state_e;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef struct packed {
    logic        ok;
    logic [31:0] idx;
  } nbr_t;

  // Neighbour of node u in direction dir; ok=0 when it would leave the grid.
  function automatic nbr_t nbr_idx(input int unsigned u, input logic [1:0] dir,
                                   input int unsigned rows, input int unsigned cols);
    int unsigned row;
    int unsigned col;
    nbr_t        r;
    row   = u / cols;
    col   = u % cols;
    r.ok  = 1'b0;
    r.idx = '0;
    case (dir)
      DIR_UP: begin
        r.ok = (row > 0);
        if (r.ok) r.idx = u - cols;
      end
      DIR_LEFT: begin
        r.ok = (col > 0);
        if (r.ok) r.idx = u - 1;
      end
      DIR_RIGHT: begin
        r.ok = (col + 1 < cols);
        if (r.ok) r.idx = u + 1;
      end
      default: begin
        r.ok = (row + 1 < rows);
        if (r.ok) r.idx = u + cols;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/grid_bfs_fifo.sv
// Circular FIFO for the BFS frontier; clear with simultaneous push restarts at entry 0.
module grid_bfs_fifo #(
  parameter int unsigned Depth = 9,
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [PtrW:0]    count_q, count_d;
  logic             pop_eff;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[head_q];
  assign pop_eff = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = push_i ? ptr_inc('0) : '0;
      count_d = push_i ? (PtrW+1)'(1) : '0;
    end else begin
      if (push_i)  tail_d = ptr_inc(tail_q);
      if (pop_eff) head_d = ptr_inc(head_q);
      count_d = count_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_eff);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[clear_i ? '0 : tail_q] <= data_i;
  end

endmodule

// File: rtl/grid_bfs_path_engine.sv
// Breadth-first shortest-path search on a ROWS x COLS grid with parent-chain path trace.
module grid_bfs_path_engine
  import grid_pkg::*;
#(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      start_i,
  input  logic [ROWS*COLS-1:0]      cell_enable_i,
  input  logic [$clog2(ROWS*COLS)-1:0] source_i,
  input  logic [$clog2(ROWS*COLS)-1:0] destination_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      found_o,
  output logic [$clog2(ROWS*COLS):0] shortest_distance_o,
  output logic [ROWS*COLS-1:0]      path_out_o
);

  localparam int unsigned N      = ROWS * COLS;
  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned DIST_W = $clog2(N) + 1;

  state_e state_q, state_d;

  logic [N-1:0]      enable_q, enable_d;
  logic [IDX_W-1:0]  src_q, src_d;
  logic [IDX_W-1:0]  dst_q, dst_d;
  logic [N-1:0]      visited_q, visited_d;
  logic [IDX_W-1:0]  parent_q [N];
  logic [IDX_W-1:0]  parent_d [N];
  logic [DIST_W-1:0] dist_q [N];
  logic [DIST_W-1:0] dist_d [N];
  logic [IDX_W-1:0]  u_q, u_d;
  logic [1:0]        dir_q, dir_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [N-1:0]      trace_q, trace_d;
  logic              found_q, found_d;
  logic [DIST_W-1:0] sdist_q, sdist_d;
  logic [N-1:0]      path_q, path_d;

  logic             fifo_clear, fifo_push, fifo_pop, fifo_empty;
  logic [IDX_W-1:0] fifo_wdata, fifo_rdata;

  nbr_t             nbr;
  logic [IDX_W-1:0] v;
  logic             qualify, hit, req_bad, same;

  grid_bfs_fifo #(
    .Depth(N),
    .Width(IDX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty)
  );

  assign nbr     = nbr_idx(32'(u_q), dir_q, ROWS, COLS);
  assign v       = IDX_W'(nbr.idx);
  assign qualify = nbr.ok && (nbr.idx < N) && enable_q[v] && !visited_q[v];
  assign hit     = qualify && (v == dst_q);
  assign req_bad = (32'(src_q) >= N) || (32'(dst_q) >= N) || !enable_q[src_q] || !enable_q[dst_q];
  assign same    = (src_q == dst_q);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StInit;
      StInit:   state_d = (req_bad || same) ? StFinish : StPop;
      StPop:    state_d = fifo_empty ? StFinish : StExpand;
      StExpand: begin
        if (hit)                    state_d = StTrace;
        else if (dir_q == DIR_DOWN) state_d = StPop;
      end
      StTrace:  if (cur_q == src_q) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy_o = (state_q != StIdle) && (state_q != StFinish);
    done_o = (state_q == StFinish);
  end

  assign found_o             = found_q;
  assign shortest_distance_o = sdist_q;
  assign path_out_o          = path_q;

  // Datapath next-state.
  always_comb begin
    enable_d   = enable_q;
    src_d      = src_q;
    dst_d      = dst_q;
    visited_d  = visited_q;
    parent_d   = parent_q;
    dist_d     = dist_q;
    u_d        = u_q;
    dir_d      = dir_q;
    cur_d      = cur_q;
    trace_d    = trace_q;
    found_d    = found_q;
    sdist_d    = sdist_q;
    path_d     = path_q;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_wdata = v;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          enable_d = cell_enable_i;
          src_d    = source_i;
          dst_d    = destination_i;
          found_d  = 1'b0;
          sdist_d  = '1;
          path_d   = '0;
        end
      end
      StInit: begin
        visited_d  = '0;
        trace_d    = '0;
        fifo_clear = 1'b1;
        for (int k = 0; k < N; k++) parent_d[k] = '0;
        if (!req_bad) begin
          visited_d[src_q] = 1'b1;
          dist_d[src_q]    = '0;
          fifo_push        = 1'b1;
          fifo_wdata       = src_q;
          if (same) begin
            found_d = 1'b1;
            sdist_d = '0;
            path_d  = N'(1) << src_q;
          end
        end
      end
      StPop: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          u_d      = fifo_rdata;
          dir_d    = DIR_UP;
        end
      end
      StExpand: begin
        if (qualify) begin
          visited_d[v] = 1'b1;
          parent_d[v]  = u_q;
          dist_d[v]    = dist_q[u_q] + DIST_W'(1);
          fifo_push    = 1'b1;
        end
        if (hit) cur_d = dst_q;
        else     dir_d = dir_q + 2'd1;
      end
      StTrace: begin
        if (cur_q == src_q) begin
          found_d = 1'b1;
          sdist_d = dist_q[dst_q];
          path_d  = trace_q | (N'(1) << src_q);
        end else begin
          trace_d = trace_q | (N'(1) << cur_q);
          cur_d   = parent_q[cur_q];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      enable_d_unused_guard: begin end
      enable_q  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      visited_q <= '0;
      for (int k = 0; k < N; k++) begin
        parent_q[k] <= '0;
        dist_q[k]   <= '0;
      end
      u_q     <= '0;
      dir_q   <= '0;
      cur_q   <= '0;
      trace_q <= '0;
      found_q <= 1'b0;
      sdist_q <= '1;
      path_q  <= '0;
    end else begin
      enable_q  <= enable_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      visited_q <= visited_d;
      parent_q  <= parent_d;
      dist_q    <= dist_d;
      u_q       <= u_d;
      dir_q     <= dir_d;
      cur_q     <= cur_d;
      trace_q   <= trace_d;
      found_q   <= found_d;
      sdist_q   <= sdist_d;
      path_q    <= path_d;
    end
  end

endmodule

// File: tb/tb_grid_bfs_path_engine.sv
// Directed checks of the grid BFS engine on a 3x3 and a 4x4 instance.
module tb_grid_bfs_path_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 3x3 instance
  logic       start_a = 1'b0;
  logic [8:0] en_a = '0;
  logic [3:0] src_a = '0, dst_a = '0;
  logic       busy_a, done_a, found_a;
  logic [4:0] dist_a;
  logic [8:0] path_a;

  // 4x4 instance
  logic        start_b = 1'b0;
  logic [15:0] en_b = '0;
  logic [3:0]  src_b = '0, dst_b = '0;
  logic        busy_b, done_b, found_b;
  logic [4:0]  dist_b;
  logic [15:0] path_b;

  int n_cmp = 0;
  int n_err = 0;

  grid_bfs_path_engine #(.ROWS(3), .COLS(3)) u_dut_a (
    .clk_i              (clk),
    .reset_ni           (rst_n),
    .start_i            (start_a),
    .cell_enable_i      (en_a),
    .source_i           (src_a),
    .destination_i      (dst_a),
    .busy_o             (busy_a),
    .done_o             (done_a),
    .found_o            (found_a),
    .shortest_distance_o(dist_a),
    .path_out_o         (path_a)
  );

  grid_bfs_path_engine #(.ROWS(4), .COLS(4)) u_dut_b (
    .clk_i              (clk),
    .reset_ni           (rst_n),
    .start_i            (start_b),
    .cell_enable_i      (en_b),
    .source_i           (src_b),
    .destination_i      (dst_b),
    .busy_o             (busy_b),
    .done_o             (done_b),
    .found_o            (found_b),
    .shortest_distance_o(dist_b),
    .path_out_o         (path_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done_a();
    int cyc = 0;
    while (!done_a && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_a_seen", 32'(done_a), 32'd1);
  endtask

  task automatic run_a(input logic [8:0] en, input logic [3:0] s, input logic [3:0] d);
    @(negedge clk);
    en_a = en; src_a = s; dst_a = d; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("busy_a_after_accept", 32'(busy_a), 32'd1);
    wait_done_a();
  endtask

  task automatic run_b(input logic [15:0] en, input logic [3:0] s, input logic [3:0] d);
    int cyc = 0;
    @(negedge clk);
    en_b = en; src_b = s; dst_b = d; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (!done_b && cyc < 800) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_b_seen", 32'(done_b), 32'd1);
  endtask

  initial begin
    int dones;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_found", 32'(found_a), 32'd0);
    check_eq("rst_dist", 32'(dist_a), 32'h1F);
    check_eq("rst_path", 32'(path_a), 32'h0);
    check_eq("rst_dist_b", 32'(dist_b), 32'h1F);
    rst_n = 1'b1;

    // 1: open grid, corner to corner
    run_a(9'h1FF, 4'd0, 4'd8);
    check_eq("t1_found", 32'(found_a), 32'd1);
    check_eq("t1_dist", 32'(dist_a), 32'd4);
    check_eq("t1_path", 32'(path_a), 32'h127);
    // start during the done cycle is ignored
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("t1_done_cycle_start_ignored", 32'(busy_a), 32'd0);
    check_eq("t1_hold_path", 32'(path_a), 32'h127);
    check_eq("t1_done_pulse", 32'(done_a), 32'd0);

    // 2: centre blocked, detour over the top
    run_a(9'h1EF, 4'd3, 4'd5);
    check_eq("t2_found", 32'(found_a), 32'd1);
    check_eq("t2_dist", 32'(dist_a), 32'd4);
    check_eq("t2_path", 32'(path_a), 32'h02F);

    // 3: column 1 blocked, unreachable
    run_a(9'h16D, 4'd0, 4'd2);
    check_eq("t3_found", 32'(found_a), 32'd0);
    check_eq("t3_dist", 32'(dist_a), 32'h1F);
    check_eq("t3_path", 32'(path_a), 32'h0);

    // 4: source equals destination, then destination out of range
    run_a(9'h1FF, 4'd4, 4'd4);
    check_eq("t4_found", 32'(found_a), 32'd1);
    check_eq("t4_dist", 32'(dist_a), 32'd0);
    check_eq("t4_path", 32'(path_a), 32'h010);
    run_a(9'h1FF, 4'd4, 4'd9);
    check_eq("t4b_found", 32'(found_a), 32'd0);
    check_eq("t4b_dist", 32'(dist_a), 32'h1F);
    check_eq("t4b_path", 32'(path_a), 32'h0);

    // 5: 4x4 open grid
    run_b(16'hFFFF, 4'd0, 4'd15);
    check_eq("t5_found", 32'(found_b), 32'd1);
    check_eq("t5_dist", 32'(dist_b), 32'd6);
    check_eq("t5_popcount", 32'($countones(path_b)), 32'd7);
    check_eq("t5_ends", 32'({path_b[15], path_b[0]}), 32'd3);

    // 6a: reset while expanding aborts without done
    @(negedge clk);
    en_a = 9'h1FF; src_a = 4'd0; dst_a = 4'd8; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t6_busy_before_reset", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("t6_busy", 32'(busy_a), 32'd0);
    check_eq("t6_found", 32'(found_a), 32'd0);
    check_eq("t6_dist", 32'(dist_a), 32'h1F);
    check_eq("t6_path", 32'(path_a), 32'h0);
    dones = 0;
    repeat (100) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check_eq("t6_no_done", 32'(dones), 32'd0);

    // 6b: start while busy is ignored
    @(negedge clk);
    en_a = 9'h1FF; src_a = 4'd0; dst_a = 4'd8; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    en_a = 9'h1FF; src_a = 4'd4; dst_a = 4'd4; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a();
    check_eq("t6b_dist", 32'(dist_a), 32'd4);
    check_eq("t6b_path", 32'(path_a), 32'h127);
    dones = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check_eq("t6b_no_second_done", 32'(dones), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
